// File: rtl/dnn_common_pkg.sv
// -----------------------------------------------------------------------------
// dnn_common_pkg
// Shared elaboration-time helpers for the neuron-lane datapath blocks.
//   DEFAULT_BIT_WIDTH : default datapath word width (16)
//   clog2()           : ceil(log2(n)), 0 for n <= 1
//   clog_radix()      : number of RADIX:1 levels needed to reduce n words to 1
//                       (never less than 1, so tiny selectors still register)
//   level_groups()    : number of RADIX:1 muxes at a given tree level
// -----------------------------------------------------------------------------
package dnn_common_pkg;

    localparam int DEFAULT_BIT_WIDTH = 16;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    function automatic int clog_radix(input int n, input int radix);
        int s;
        int cap;
        s   = 0;
        cap = 1;
        while (cap < n) begin
            cap = cap * radix;
            s++;
        end
        // A selector with n <= radix still gets one registered level.
        if (s < 1) begin
            s = 1;
        end
        return s;
    endfunction

    // Level 0 sees n words; every later level sees one word per group of the
    // level before it.
    function automatic int level_groups(input int n, input int radix, input int level);
        int w;
        int g;
        w = n;
        g = n;
        for (int i = 0; i <= level; i++) begin
            g = (w + radix - 1) / radix;
            w = g;
        end
        return g;
    endfunction

endpackage

// File: rtl/mux_n_to_1_pipe_if.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_pipe_if
// Bundle of the selector's input-beat and output-beat channels.
//   i_valid/o_ready/i_sel/i_A : input channel (producer -> selector)
//   o_valid/i_ready/o_B/o_err : output channel (selector -> consumer)
//
// Handshake (both channels): a beat transfers on a rising clk edge where
// valid && ready are both high. The sender holds valid and payload steady
// until that edge; ready may rise or fall freely and never depends on valid
// of the same channel.
//
// Modports: slave = the selector itself, master = the producer/consumer side.
// -----------------------------------------------------------------------------
interface mux_n_to_1_pipe_if
    import dnn_common_pkg::*;
#(
    parameter int BIT_WIDTH  = DEFAULT_BIT_WIDTH,
    parameter int NUM_INPUTS = 81
);
    localparam int SEL_WIDTH = clog2(NUM_INPUTS);

    logic                            i_valid;
    logic                            o_ready;
    logic [SEL_WIDTH-1:0]            i_sel;
    logic [NUM_INPUTS*BIT_WIDTH-1:0] i_A;
    logic                            o_valid;
    logic                            i_ready;
    logic [BIT_WIDTH-1:0]            o_B;
    logic                            o_err;

    modport slave (
        input  i_valid, i_sel, i_A, i_ready,
        output o_ready, o_valid, o_B, o_err
    );

    modport master (
        output i_valid, i_sel, i_A, i_ready,
        input  o_ready, o_valid, o_B, o_err
    );

endinterface

// File: rtl/mux_radix_stage.sv
// -----------------------------------------------------------------------------
// mux_radix_stage
// One level of the pipelined selector tree: NUM_GROUPS independent RADIX:1
// muxes sharing one select digit, followed by a register slice with its own
// valid bit and elastic ready.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : upstream beat valid        in_ready  : this level can load
//   in_data    : NUM_GROUPS*RADIX words (group g = words g*RADIX..+RADIX-1)
//   in_sel     : select field, low clog2(RADIX) bits consumed here
//   in_err     : out-of-range flag travelling with the beat
//   out_valid  : registered beat valid       out_ready : downstream can load
//   out_data   : NUM_GROUPS registered words
//   out_sel    : select field shifted down by one digit
//   out_err    : registered err flag
// -----------------------------------------------------------------------------
module mux_radix_stage
    import dnn_common_pkg::*;
#(
    parameter int RADIX         = 16,
    parameter int BIT_WIDTH     = DEFAULT_BIT_WIDTH,
    parameter int NUM_GROUPS    = 1,
    parameter int REM_SEL_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_GROUPS*RADIX*BIT_WIDTH-1:0] in_data,
    input  logic [REM_SEL_WIDTH-1:0]          in_sel,
    input  logic                              in_err,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_GROUPS*BIT_WIDTH-1:0]   out_data,
    output logic [REM_SEL_WIDTH-1:0]          out_sel,
    output logic                              out_err
);
    localparam int LVL_BITS = clog2(RADIX);

    logic [LVL_BITS-1:0]             leg;
    logic [NUM_GROUPS*BIT_WIDTH-1:0] mux_data;

    logic                            valid_q;
    logic [NUM_GROUPS*BIT_WIDTH-1:0] data_q;
    logic [REM_SEL_WIDTH-1:0]        sel_q;
    logic                            err_q;

    assign leg = in_sel[LVL_BITS-1:0];

    // Empty slot, or the slot drains this same cycle.
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        mux_data = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            mux_data[g*BIT_WIDTH +: BIT_WIDTH] =
                in_data[(g*RADIX + int'(leg))*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            // Payload only moves with a real beat, so a bubble leaves the
            // last word in place instead of toggling the datapath.
            if (in_valid) begin
                data_q <= mux_data;
                sel_q  <= in_sel >> LVL_BITS;
                err_q  <= in_err;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_err   = err_q;

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_pipe
// Pipelined N:1 word selector built from RADIX:1 levels, one register stage
// per level, with an elastic valid/ready handshake front and back.
//   clk  : clock
//   rst  : synchronous active-high reset, drops every in-flight beat
//   bus  : mux_n_to_1_pipe_if.slave
//            i_valid/o_ready/i_sel/i_A in, o_valid/i_ready/o_B/o_err out
// Latency is NUM_STAGES cycles with i_ready held high, one beat per cycle.
// A beat with i_sel >= NUM_INPUTS comes out with o_err = 1 and o_B = 0.
// The interface instance must carry the same BIT_WIDTH/NUM_INPUTS as this
// module.
// -----------------------------------------------------------------------------
module mux_n_to_1_pipe
    import dnn_common_pkg::*;
#(
    parameter int BIT_WIDTH  = DEFAULT_BIT_WIDTH,
    parameter int NUM_INPUTS = 81,
    parameter int RADIX      = 16
) (
    input  logic             clk,
    input  logic             rst,
    mux_n_to_1_pipe_if.slave bus
);
    localparam int LVL_BITS   = clog2(RADIX);
    localparam int NUM_STAGES = clog_radix(NUM_INPUTS, RADIX);
    // One select digit per level; RADIX**NUM_STAGES >= NUM_INPUTS guarantees
    // this is at least as wide as i_sel.
    localparam int SEL_PAD_W  = NUM_STAGES * LVL_BITS;
    localparam int LAST       = NUM_STAGES - 1;

    logic sel_oob;
    assign sel_oob = 32'(bus.i_sel) >= NUM_INPUTS;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_lvl
        localparam int GROUPS = level_groups(NUM_INPUTS, RADIX, k);
        localparam int IN_W   = GROUPS * RADIX * BIT_WIDTH;

        logic [IN_W-1:0]             in_data;
        logic [SEL_PAD_W-1:0]        in_sel;
        logic                        in_valid;
        logic                        in_ready;
        logic                        in_err;
        logic                        out_valid;
        logic                        out_ready;
        logic [GROUPS*BIT_WIDTH-1:0] out_data;
        logic [SEL_PAD_W-1:0]        out_sel;
        logic                        out_err;

        // Zero-extension pads the last partial group, so unused legs read 0.
        if (k == 0) begin : g_head
            assign in_data  = IN_W'(bus.i_A);
            assign in_sel   = SEL_PAD_W'(bus.i_sel);
            assign in_valid = bus.i_valid;
            assign in_err   = sel_oob;
        end else begin : g_body
            assign in_data  = IN_W'(g_lvl[k-1].out_data);
            assign in_sel   = g_lvl[k-1].out_sel;
            assign in_valid = g_lvl[k-1].out_valid;
            assign in_err   = g_lvl[k-1].out_err;
        end

        // Ready ripples combinationally from the consumer back to o_ready.
        if (k == LAST) begin : g_tail
            assign out_ready = bus.i_ready;
        end else begin : g_link
            assign out_ready = g_lvl[k+1].in_ready;
        end

        mux_radix_stage #(
            .RADIX         (RADIX),
            .BIT_WIDTH     (BIT_WIDTH),
            .NUM_GROUPS    (GROUPS),
            .REM_SEL_WIDTH (SEL_PAD_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_sel    (in_sel),
            .in_err    (in_err),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_sel   (out_sel),
            .out_err   (out_err)
        );
    end

    // All select digits are consumed by the last level; anything left over
    // can only mean the index ran past the tree, so it counts as out of range.
    logic final_err;
    assign final_err = g_lvl[LAST].out_err || (|g_lvl[LAST].out_sel);

    assign bus.o_ready = g_lvl[0].in_ready;
    assign bus.o_valid = g_lvl[LAST].out_valid;
    assign bus.o_err   = final_err;
    assign bus.o_B     = final_err ? '0 : g_lvl[LAST].out_data;

endmodule
